mac_dot_sequencer: RTL and testbench

- Sequences one signed 16x16 accumulate-mode MAC for an N-tap dot product (FIR tap sum) in Q2.14.
- Issues coefficient-ROM and sample-ring-buffer read addresses and drives the MAC operands, clear and clock-enable.
- Accounts for memory and MAC pipeline latency, then rounds and saturates the 32-bit Q4.28 accumulator to Q2.14.
- Returns the result over a valid/ready handshake to the downstream audio pipeline.

---
 rtl/mac_seq_pkg.sv | 18 +
 rtl/q428_to_q214_sat.sv | 29 ++
 rtl/mac_dot_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mac_dot_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and Q-format constants for the dot-product MAC sequencer.
// The accumulator is Q4.28; results returned downstream are Q2.14.
package mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_DRAIN,
        S_OUTPUT
    } mac_seq_state_t;

    localparam int               FRAC_BITS   = 14;
    localparam logic signed [32:0] ROUND_CONST = 33'sd8192;
    localparam logic [15:0]      Q_MAX       = 16'h7FFF;
    localparam logic [15:0]      Q_MIN       = 16'h8000;

endpackage

// File: rtl/q428_to_q214_sat.sv
// Round-half-up and saturate a signed Q4.28 accumulator down to signed Q2.14.
module q428_to_q214_sat
    import mac_seq_pkg::*;
(
    input  logic [31:0] in,
    output logic [15:0] out,
    output logic        sat
);

    logic signed [32:0] sum;
    logic signed [32:0] r;

    always_comb begin
        // One guard bit so adding the rounding constant cannot wrap.
        sum = $signed({in[31], in}) + ROUND_CONST;
        r   = sum >>> FRAC_BITS;
        if (r > 33'sd32767) begin
            out = Q_MAX;
            sat = 1'b1;
        end else if (r < -33'sd32768) begin
            out = Q_MIN;
            sat = 1'b1;
        end else begin
            out = r[15:0];
            sat = 1'b0;
        end
    end

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences an N-tap dot product through an external accumulate-mode MAC,
// issuing ROM/ring addresses and returning a rounded Q2.14 result over valid/ready.
module mac_dot_sequencer
    import mac_seq_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 1,
    parameter int MAC_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              start_ready,
    input  logic [ADDR_W:0]   taps,
    input  logic [ADDR_W-1:0] base,
    input  logic              abort,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [ADDR_W-1:0] samp_addr,
    input  logic [15:0]       coef_data,
    input  logic [15:0]       samp_data,
    output logic [15:0]       mac_a,
    output logic [15:0]       mac_b,
    output logic              mac_ce,
    output logic              mac_rst,
    input  logic [31:0]       mac_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic              out_sat
);

    localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W + 1)'(MEM_LAT + MAC_LAT - 1);

    mac_seq_state_t    state_q, state_d;
    logic [ADDR_W:0]   taps_q, taps_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] coef_addr_q, coef_addr_d;
    logic [ADDR_W-1:0] samp_addr_q, samp_addr_d;
    logic              mac_rst_q, mac_rst_d;
    logic [MEM_LAT-1:0] issue_pipe_q, issue_pipe_d;
    logic              out_valid_q, out_valid_d;
    logic [15:0]       out_data_q, out_data_d;
    logic              out_sat_q, out_sat_d;

    logic [15:0]       sat_data;
    logic              sat_flag;
    logic              abort_hit;

    q428_to_q214_sat u_sat (
        .in  (mac_result),
        .out (sat_data),
        .sat (sat_flag)
    );

    assign abort_hit = abort && (state_q != S_IDLE);

    // mac_ce follows ISSUE by the memory latency so it brackets exactly the valid read data.
    assign issue_pipe_d[0] = (state_q == S_ISSUE) && !abort_hit;
    genvar gi;
    for (gi = 1; gi < MEM_LAT; gi++) begin : g_issue_pipe
        assign issue_pipe_d[gi] = issue_pipe_q[gi-1] && !abort_hit;
    end

    always_comb begin
        state_d     = state_q;
        taps_d      = taps_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        coef_addr_d = coef_addr_q;
        samp_addr_d = samp_addr_q;
        mac_rst_d   = 1'b1;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    taps_d    = taps;
                    base_d    = base;
                    mac_rst_d = 1'b0;
                    state_d   = S_CLEAR;
                end
            end
            S_CLEAR: begin
                cnt_d = '0;
                if (taps_q != '0) begin
                    coef_addr_d = '0;
                    samp_addr_d = base_q;
                    state_d     = S_ISSUE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_ISSUE: begin
                if (cnt_q + 1'b1 == taps_q) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    coef_addr_d = coef_addr_q + 1'b1;
                    samp_addr_d = samp_addr_q - 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    out_data_d  = sat_data;
                    out_sat_d   = sat_flag;
                    out_valid_d = 1'b1;
                    state_d     = S_OUTPUT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Clearing on abort keeps a half-finished sum from leaking into the next request.
        if (abort_hit) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            mac_rst_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            taps_q       <= '0;
            base_q       <= '0;
            cnt_q        <= '0;
            coef_addr_q  <= '0;
            samp_addr_q  <= '0;
            mac_rst_q    <= 1'b0;
            issue_pipe_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            coef_addr_q  <= coef_addr_d;
            samp_addr_q  <= samp_addr_d;
            mac_rst_q    <= mac_rst_d;
            issue_pipe_q <= issue_pipe_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign coef_addr   = coef_addr_q;
    assign samp_addr   = samp_addr_q;
    assign mac_a       = coef_data;
    assign mac_b       = samp_data;
    assign mac_ce      = issue_pipe_q[MEM_LAT-1];
    assign mac_rst     = mac_rst_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with 1-cycle memories and a 2-stage accumulate MAC model.
module tb_mac_dot_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        start_ready;
    logic [6:0]  taps = '0;
    logic [5:0]  base = '0;
    logic        abort = 1'b0;
    logic [5:0]  coef_addr;
    logic [5:0]  samp_addr;
    logic [15:0] coef_data;
    logic [15:0] samp_data;
    logic [15:0] mac_a;
    logic [15:0] mac_b;
    logic        mac_ce;
    logic        mac_rst;
    logic [31:0] mac_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        out_sat;

    int checks = 0;
    int failures = 0;

    mac_dot_sequencer #(.ADDR_W(6), .MEM_LAT(1), .MAC_LAT(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .start_ready (start_ready),
        .taps        (taps),
        .base        (base),
        .abort       (abort),
        .coef_addr   (coef_addr),
        .samp_addr   (samp_addr),
        .coef_data   (coef_data),
        .samp_data   (samp_data),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_ce      (mac_ce),
        .mac_rst     (mac_rst),
        .mac_result  (mac_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_sat     (out_sat)
    );

    always #5 clk = ~clk;

    // Memories and MAC model
    logic [15:0]        coef_mem [64];
    logic [15:0]        samp_mem [64];
    logic [15:0]        coef_rd = '0;
    logic [15:0]        samp_rd = '0;
    logic signed [31:0] p1 = '0;
    logic               v1 = 1'b0;
    logic signed [31:0] acc = '0;

    assign coef_data  = coef_rd;
    assign samp_data  = samp_rd;
    assign mac_result = acc;

    always @(posedge clk) begin
        coef_rd <= coef_mem[coef_addr];
        samp_rd <= samp_mem[samp_addr];
        if (!mac_rst) begin
            p1  <= '0;
            v1  <= 1'b0;
            acc <= '0;
        end else begin
            v1 <= mac_ce;
            p1 <= $signed(mac_a) * $signed(mac_b);
            if (v1) acc <= acc + p1;
        end
    end

    // Observations from the most recent run_dot
    int          obs_vcyc;
    logic [15:0] obs_data;
    logic        obs_sat;
    logic [127:0] obs_ce;
    logic [5:0]  obs_coef [64];
    logic [5:0]  obs_samp [64];
    logic        obs_sr0;
    int          obs_unstable;
    logic        obs_v_after;
    logic        obs_sr_after;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input logic [15:0] c, input logic [15:0] s);
        for (int i = 0; i < 64; i++) begin
            coef_mem[i] = c;
            samp_mem[i] = s;
        end
    endtask

    function automatic logic [127:0] ce_mask(input int n);
        logic [127:0] m;
        m = '0;
        for (int i = 3; i <= n + 2; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Starts a request in the current cycle (cycle 0) and records what the DUT does.
    task automatic run_dot(input int n, input logic [5:0] b, input int hold);
        int cyc;
        bit seen;
        obs_vcyc = -1; obs_ce = '0; obs_unstable = 0; seen = 0;
        obs_v_after = 1'bx; obs_sr_after = 1'bx;
        out_ready = (hold == 0);
        taps = 7'(n); base = b; start = 1'b1;
        obs_sr0 = start_ready;
        cyc = 0;
        while (!seen && cyc < 200) begin
            step();
            cyc++;
            start = 1'b0;
            if (mac_ce === 1'b1 && cyc < 128) obs_ce[cyc] = 1'b1;
            if (cyc >= 2 && cyc - 2 < n) begin
                obs_coef[cyc-2] = coef_addr;
                obs_samp[cyc-2] = samp_addr;
            end
            if (out_valid === 1'b1) begin
                seen = 1; obs_vcyc = cyc; obs_data = out_data; obs_sat = out_sat;
            end
        end
        if (seen) begin
            for (int i = 1; i < hold; i++) begin
                start = 1'b1; taps = 7'd1;
                step();
                if (out_valid !== 1'b1 || out_data !== obs_data || out_sat !== obs_sat ||
                    start_ready !== 1'b0) obs_unstable++;
            end
            start = 1'b0; out_ready = 1'b1;
            step();
            obs_v_after = out_valid; obs_sr_after = start_ready;
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step(); step();
        checks++;
        if ({out_valid, out_data, out_sat, mac_ce, mac_rst} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b data=%h sat=%b ce=%b rst=%b exp all zero",
                     out_valid, out_data, out_sat, mac_ce, mac_rst);
        end
        checks++;
        if (coef_addr !== 6'd0 || samp_addr !== 6'd0 || start_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_addr got coef=%0d samp=%0d ready=%b exp 0 0 1",
                     coef_addr, samp_addr, start_ready);
        end
        reset = 1'b1;
        step(); step();
        checks++;
        if (mac_rst !== 1'b1) begin
            failures++;
            $display("FAIL idle_mac_rst got=%b exp=1", mac_rst);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        fill_mem(16'h2000, 16'h1000);
        run_dot(4, 6'd10, 0);
        checks++;
        if (obs_sr0 !== 1'b1) begin
            failures++; $display("FAIL basic_start_ready got=%b exp=1", obs_sr0);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_coef[k] !== 6'(k) || obs_samp[k] !== 6'(10 - k)) begin
                failures++;
                $display("FAIL basic_addr k=%0d got coef=%0d samp=%0d exp coef=%0d samp=%0d",
                         k, obs_coef[k], obs_samp[k], k, 10 - k);
            end
        end
        checks++;
        if (obs_ce !== ce_mask(4)) begin
            failures++; $display("FAIL basic_ce got=%h exp=%h", obs_ce, ce_mask(4));
        end
        checks++;
        if (obs_vcyc !== 9) begin
            failures++; $display("FAIL basic_latency got=%0d exp=9", obs_vcyc);
        end
        // 4 x (0.5 * 0.25) = 0.5
        checks++;
        if (obs_data !== 16'h2000 || obs_sat !== 1'b0) begin
            failures++; $display("FAIL basic_data got=%h sat=%b exp=2000 sat=0", obs_data, obs_sat);
        end
        checks++;
        if (obs_v_after !== 1'b0 || obs_sr_after !== 1'b1) begin
            failures++;
            $display("FAIL basic_handshake got valid=%b ready=%b exp 0 1", obs_v_after, obs_sr_after);
        end
        $display("test_basic data=%h sat=%b latency=%0d", obs_data, obs_sat, obs_vcyc);
    endtask

    task automatic test_wrap();
        logic [5:0] exp_samp [4];
        exp_samp[0] = 6'd2; exp_samp[1] = 6'd1; exp_samp[2] = 6'd0; exp_samp[3] = 6'd63;
        for (int i = 0; i < 64; i++) begin
            coef_mem[i] = (i < 4) ? 16'(16'h4000 - i * 16'h1000) : 16'h0;
            samp_mem[i] = 16'(i * 16'h100);
        end
        run_dot(4, 6'd2, 0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_samp[k] !== exp_samp[k]) begin
                failures++;
                $display("FAIL wrap_addr k=%0d got=%0d exp=%0d", k, obs_samp[k], exp_samp[k]);
            end
        end
        // 1.0*0x200 + 0.75*0x100 + 0.5*0 + 0.25*0x3F00 = 512+192+0+4032 = 0x1280
        checks++;
        if (obs_data !== 16'h1280 || obs_sat !== 1'b0) begin
            failures++; $display("FAIL wrap_data got=%h sat=%b exp=1280 sat=0", obs_data, obs_sat);
        end
        $display("test_wrap data=%h sat=%b", obs_data, obs_sat);
    endtask

    task automatic test_saturation();
        // 8 x (0.99997 * 0.5) ~= 4.0 stays inside 32 bits but exceeds Q2.14
        fill_mem(16'h7FFF, 16'h2000);
        run_dot(8, 6'd20, 0);
        checks++;
        if (obs_data !== 16'h7FFF || obs_sat !== 1'b1 || obs_vcyc !== 13) begin
            failures++;
            $display("FAIL sat_pos got=%h sat=%b lat=%0d exp=7fff sat=1 lat=13", obs_data, obs_sat, obs_vcyc);
        end
        fill_mem(16'h7FFF, 16'hE000);
        run_dot(8, 6'd20, 0);
        checks++;
        if (obs_data !== 16'h8000 || obs_sat !== 1'b1) begin
            failures++; $display("FAIL sat_neg got=%h sat=%b exp=8000 sat=1", obs_data, obs_sat);
        end
        $display("test_saturation last data=%h sat=%b", obs_data, obs_sat);
    endtask

    task automatic test_rounding();
        logic [15:0] samp_v [3];
        logic [15:0] exp_v  [3];
        samp_v[0] = 16'h2000; exp_v[0] = 16'h0001;   // exactly half an LSB rounds up
        samp_v[1] = 16'h1FFF; exp_v[1] = 16'h0000;   // just under half rounds down
        samp_v[2] = 16'hDFFF; exp_v[2] = 16'hFFFF;   // -8193/16384 LSB rounds to -1
        for (int t = 0; t < 3; t++) begin
            fill_mem(16'h0001, samp_v[t]);
            run_dot(1, 6'd5, 0);
            checks++;
            if (obs_data !== exp_v[t] || obs_sat !== 1'b0 || obs_vcyc !== 6) begin
                failures++;
                $display("FAIL round_%0d got=%h sat=%b lat=%0d exp=%h sat=0 lat=6",
                         t, obs_data, obs_sat, obs_vcyc, exp_v[t]);
            end
        end
        $display("test_rounding done");
    endtask

    task automatic test_zero_taps();
        fill_mem(16'h4000, 16'h4000);
        run_dot(0, 6'd7, 0);
        checks++;
        if (obs_ce !== '0) begin
            failures++; $display("FAIL zero_ce got=%h exp=0", obs_ce);
        end
        checks++;
        if (obs_data !== 16'h0000 || obs_sat !== 1'b0 || obs_vcyc !== 5) begin
            failures++;
            $display("FAIL zero_data got=%h sat=%b lat=%0d exp=0000 sat=0 lat=5", obs_data, obs_sat, obs_vcyc);
        end
        $display("test_zero_taps data=%h latency=%0d", obs_data, obs_vcyc);
    endtask

    task automatic test_backpressure();
        fill_mem(16'h2000, 16'h1000);
        run_dot(4, 6'd10, 5);
        checks++;
        if (obs_unstable !== 0) begin
            failures++; $display("FAIL bp_stable got=%0d unstable cycles exp=0", obs_unstable);
        end
        checks++;
        if (obs_data !== 16'h2000 || obs_vcyc !== 9) begin
            failures++; $display("FAIL bp_data got=%h lat=%0d exp=2000 lat=9", obs_data, obs_vcyc);
        end
        checks++;
        if (obs_v_after !== 1'b0 || obs_sr_after !== 1'b1) begin
            failures++;
            $display("FAIL bp_handshake got valid=%b ready=%b exp 0 1", obs_v_after, obs_sr_after);
        end
        $display("test_backpressure data=%h unstable=%0d", obs_data, obs_unstable);
    endtask

    task automatic test_abort();
        int vcount;
        fill_mem(16'h2000, 16'h1000);
        taps = 7'd4; base = 6'd10; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        checks++;
        if (coef_addr !== 6'd2 || mac_ce !== 1'b1) begin
            failures++; $display("FAIL abort_pos got coef=%0d ce=%b exp 2 1", coef_addr, mac_ce);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (mac_rst !== 1'b0 || mac_ce !== 1'b0 || start_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL abort_idle got rst=%b ce=%b ready=%b valid=%b exp 0 0 1 0",
                     mac_rst, mac_ce, start_ready, out_valid);
        end
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 0) begin
            failures++; $display("FAIL abort_no_valid got=%0d exp=0", vcount);
        end
        run_dot(4, 6'd10, 0);
        checks++;
        if (obs_data !== 16'h2000 || obs_vcyc !== 9) begin
            failures++; $display("FAIL abort_rerun got=%h lat=%0d exp=2000 lat=9", obs_data, obs_vcyc);
        end
        $display("test_abort rerun data=%h", obs_data);
    endtask

    task automatic test_async_reset();
        int vcount;
        fill_mem(16'h2000, 16'h1000);
        taps = 7'd4; base = 6'd10; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_data, out_sat, mac_ce, mac_rst} !== 20'h0 ||
            coef_addr !== 6'd0 || samp_addr !== 6'd0 || start_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_reset got valid=%b data=%h ce=%b rst=%b coef=%0d samp=%0d ready=%b exp zeros ready=1",
                     out_valid, out_data, mac_ce, mac_rst, coef_addr, samp_addr, start_ready);
        end
        step(); step();
        reset = 1'b1;
        vcount = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_valid === 1'b1) vcount++;
        end
        checks++;
        if (vcount !== 0) begin
            failures++; $display("FAIL reset_no_valid got=%0d exp=0", vcount);
        end
        run_dot(4, 6'd10, 0);
        checks++;
        if (obs_data !== 16'h2000 || obs_vcyc !== 9) begin
            failures++; $display("FAIL reset_rerun got=%h lat=%0d exp=2000 lat=9", obs_data, obs_vcyc);
        end
        $display("test_async_reset rerun data=%h", obs_data);
    endtask

    initial begin
        fill_mem(16'h0, 16'h0);
        test_reset();
        test_basic();
        test_wrap();
        test_saturation();
        test_zero_taps();
        test_rounding();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
